// File: rtl/tm1638_keys.sv
// TM1638 key-scan reader: sends 0x42, reads 4 bytes, and presents the 8 buttons; one scan is 85 clken ticks.
// There is no backpressure. A start while busy is dropped, and a poll expiry while busy is held in pending.
module tm1638_keys #(
  parameter int WAIT_TICKS = 3,
  parameter int POLL_TICKS = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clken,
  input  logic       start,
  input  logic       tm1638_dio_i,
  output logic       tm1638_stb,
  output logic       tm1638_clk,
  output logic       tm1638_dio_o,
  output logic       tm1638_dio_oe,
  output logic       busy,
  output logic [7:0] keys,
  output logic       key_valid,
  output logic       key_change
);

  localparam logic [7:0] CMD_READ = 8'h42;

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_WAIT, S_READ, S_END} state_t;

  state_t      state;
  logic        phase_b;
  logic [4:0]  bit_idx;
  logic [7:0]  wait_cnt;
  logic [31:0] shreg;
  logic [31:0] poll_cnt;
  logic        pending;
  logic        dio_s1;
  logic        dio_s2;
  logic        poll_hit;
  logic [7:0]  new_keys;

  always_ff @(posedge clk) begin
    if (reset) begin
      dio_s1 <= 1'b1;
      dio_s2 <= 1'b1;
    end else begin
      dio_s1 <= tm1638_dio_i;
      dio_s2 <= dio_s1;
    end
  end

  assign poll_hit = clken && (POLL_TICKS != 0) && (poll_cnt == 32'(POLL_TICKS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      poll_cnt <= '0;
    end else if (clken && (POLL_TICKS != 0)) begin
      poll_cnt <= poll_hit ? '0 : poll_cnt + 32'd1;
    end
  end

  // Each button appears as bit 0 and bit 4 of one of the four scan bytes.
  always_comb begin
    new_keys = '0;
    for (int i = 0; i < 4; i++) begin
      new_keys[i]     = shreg[8*i];
      new_keys[i + 4] = shreg[8*i + 4];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      tm1638_stb    <= 1'b1;
      tm1638_clk    <= 1'b1;
      tm1638_dio_o  <= 1'b1;
      tm1638_dio_oe <= 1'b0;
      busy          <= 1'b0;
      keys          <= '0;
      key_valid     <= 1'b0;
      key_change    <= 1'b0;
      pending       <= 1'b0;
      phase_b       <= 1'b0;
      bit_idx       <= '0;
      wait_cnt      <= '0;
      shreg         <= '0;
    end else begin
      key_valid  <= 1'b0;
      key_change <= 1'b0;
      case (state)
        S_IDLE: begin
          // busy drops one clk after STB rises, so a new scan starts no earlier than the next tick.
          if (busy) begin
            busy <= 1'b0;
          end else if (clken && (start || pending)) begin
            tm1638_stb    <= 1'b0;
            tm1638_clk    <= 1'b1;
            tm1638_dio_oe <= 1'b1;
            busy          <= 1'b1;
            pending       <= 1'b0;
            bit_idx       <= '0;
            phase_b       <= 1'b0;
            state         <= S_CMD;
          end
        end
        S_CMD: if (clken) begin
          if (!phase_b) begin
            tm1638_clk   <= 1'b0;
            tm1638_dio_o <= CMD_READ[bit_idx[2:0]];
            phase_b      <= 1'b1;
          end else begin
            tm1638_clk <= 1'b1;
            phase_b    <= 1'b0;
            if (bit_idx == 5'd7) begin
              bit_idx  <= '0;
              wait_cnt <= '0;
              state    <= S_WAIT;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        S_WAIT: if (clken) begin
          tm1638_dio_oe <= 1'b0;
          tm1638_dio_o  <= 1'b1;
          if (wait_cnt == 8'(WAIT_TICKS - 1)) begin
            state <= S_READ;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        S_READ: if (clken) begin
          if (!phase_b) begin
            tm1638_clk <= 1'b0;
            phase_b    <= 1'b1;
          end else begin
            tm1638_clk <= 1'b1;
            phase_b    <= 1'b0;
            shreg      <= {dio_s2, shreg[31:1]};
            if (bit_idx == 5'd31) begin
              state <= S_END;
            end else begin
              bit_idx <= bit_idx + 5'd1;
            end
          end
        end
        S_END: if (clken) begin
          tm1638_stb <= 1'b1;
          tm1638_clk <= 1'b1;
          keys       <= new_keys;
          key_valid  <= 1'b1;
          key_change <= (new_keys != keys);
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
      // An expiry takes priority over the clear at scan start.
      if (poll_hit) pending <= 1'b1;
    end
  end

endmodule
